// File: rtl/gullfaxi_pkg.sv
// Shared constants and state types for the gullfaxi byte packet router.
package gullfaxi_pkg;

   localparam int         NUM_PORTS = 3;
   localparam int         DATA_W    = 8;
   localparam int         LEN_W     = 6;
   localparam int         MAX_LEN   = 63;
   localparam logic [1:0] DEST_DROP = 2'd3;

   typedef enum logic [1:0] {IDLE, WAIT, RECV, DROP} in_state_t;
   typedef enum logic [1:0] {EMPTY, FULL, SEND} out_state_t;

endpackage

// File: rtl/gullfaxi_out_port.sv
// One output channel: packet buffer, length register and the req/grant/send state machine.
module gullfaxi_out_port
   import gullfaxi_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [LEN_W-1:0]  wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              commit,
   input  logic [LEN_W-1:0]  commit_len,
   input  logic              grant,
   output logic              req,
   output logic              start,
   output logic [LEN_W-1:0]  length,
   output logic [DATA_W-1:0] data,
   output logic              pkt_end,
   output logic              is_empty,
   output logic              frees
);

   logic [DATA_W-1:0] mem [0:(1<<LEN_W)-1];
   out_state_t        state;
   logic [LEN_W-1:0]  len;
   logic [LEN_W-1:0]  rd_ptr;

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   // Outputs are registered so byte 0 appears the cycle after the grant edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= EMPTY;
         len     <= '0;
         rd_ptr  <= '0;
         req     <= 1'b0;
         start   <= 1'b0;
         length  <= '0;
         data    <= '0;
         pkt_end <= 1'b0;
      end else begin
         case (state)
            EMPTY: begin
               if (commit) begin
                  state <= FULL;
                  len   <= commit_len;
                  req   <= 1'b1;
               end
            end
            FULL: begin
               if (grant) begin
                  state   <= SEND;
                  req     <= 1'b0;
                  start   <= 1'b1;
                  length  <= len;
                  data    <= mem[0];
                  pkt_end <= (len == LEN_W'(1));
                  rd_ptr  <= LEN_W'(1);
               end
            end
            SEND: begin
               if (pkt_end) begin
                  state   <= EMPTY;
                  start   <= 1'b0;
                  length  <= '0;
                  data    <= '0;
                  pkt_end <= 1'b0;
               end else begin
                  start   <= 1'b0;
                  length  <= '0;
                  data    <= mem[rd_ptr];
                  pkt_end <= (rd_ptr == len - 1'b1);
                  rd_ptr  <= rd_ptr + 1'b1;
               end
            end
            default: state <= EMPTY;
         endcase
      end
   end

   assign is_empty = (state == EMPTY);
   // High during the last byte, so a waiting input can resume on the very next cycle.
   assign frees    = (state == SEND) && pkt_end;

endmodule

// File: rtl/gullfaxi.sv
// Store-and-forward router: one ready/valid byte input, three buffered arbitrated outputs.
module gullfaxi
   import gullfaxi_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              I0_valid,
   input  logic [DATA_W-1:0] I0_data,
   input  logic              I0_end,
   output logic              I0_ready,
   output logic              O0_start,
   output logic [LEN_W-1:0]  O0_length,
   output logic [DATA_W-1:0] O0_data,
   output logic              O0_end,
   output logic              O0_req,
   input  logic              O0_grant,
   output logic              O1_start,
   output logic [LEN_W-1:0]  O1_length,
   output logic [DATA_W-1:0] O1_data,
   output logic              O1_end,
   output logic              O1_req,
   input  logic              O1_grant,
   output logic              O2_start,
   output logic [LEN_W-1:0]  O2_length,
   output logic [DATA_W-1:0] O2_data,
   output logic              O2_end,
   output logic              O2_req,
   input  logic              O2_grant
);

   in_state_t             in_state;
   logic [1:0]            dest;
   logic [LEN_W-1:0]      count;
   logic                  accept;
   logic                  store;
   logic                  commit;
   logic                  dest_empty;
   logic                  dest_frees;
   logic [3:0]            empty_ext;
   logic [3:0]            frees_ext;
   logic [NUM_PORTS-1:0]  port_grant;
   logic [NUM_PORTS-1:0]  port_wr_en;
   logic [NUM_PORTS-1:0]  port_commit;
   logic [NUM_PORTS-1:0]  port_req;
   logic [NUM_PORTS-1:0]  port_start;
   logic [NUM_PORTS-1:0]  port_end;
   logic [NUM_PORTS-1:0]  port_empty;
   logic [NUM_PORTS-1:0]  port_frees;
   logic [LEN_W-1:0]      port_length [NUM_PORTS];
   logic [DATA_W-1:0]     port_data   [NUM_PORTS];

   assign I0_ready   = reset && (in_state != WAIT);
   assign accept     = I0_valid && I0_ready;
   // A byte arriving with count at MAX_LEN would be payload byte 64, so it is never stored.
   assign store      = accept && (in_state == RECV) && (count != LEN_W'(MAX_LEN));
   assign commit     = store && I0_end;
   assign empty_ext  = {1'b0, port_empty};
   assign frees_ext  = {1'b0, port_frees};
   assign dest_empty = empty_ext[I0_data[1:0]];
   assign dest_frees = frees_ext[dest];
   assign port_grant = {O2_grant, O1_grant, O0_grant};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         in_state <= IDLE;
         dest     <= '0;
         count    <= '0;
      end else begin
         case (in_state)
            IDLE: begin
               if (accept && !I0_end) begin
                  dest  <= I0_data[1:0];
                  count <= '0;
                  if (I0_data[1:0] == DEST_DROP) in_state <= DROP;
                  else if (dest_empty)           in_state <= RECV;
                  else                           in_state <= WAIT;
               end
            end
            WAIT: begin
               if (dest_frees) in_state <= RECV;
            end
            RECV: begin
               if (accept) begin
                  if (count == LEN_W'(MAX_LEN)) in_state <= I0_end ? IDLE : DROP;
                  else if (I0_end)              in_state <= IDLE;
                  else                          count    <= count + 1'b1;
               end
            end
            DROP: begin
               if (accept && I0_end) in_state <= IDLE;
            end
            default: in_state <= IDLE;
         endcase
      end
   end

   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
      assign port_wr_en[p]  = store && (dest == 2'(p));
      assign port_commit[p] = commit && (dest == 2'(p));

      gullfaxi_out_port u_port (
         .clk        (clk),
         .reset      (reset),
         .wr_en      (port_wr_en[p]),
         .wr_addr    (count),
         .wr_data    (I0_data),
         .commit     (port_commit[p]),
         .commit_len (count + 1'b1),
         .grant      (port_grant[p]),
         .req        (port_req[p]),
         .start      (port_start[p]),
         .length     (port_length[p]),
         .data       (port_data[p]),
         .pkt_end    (port_end[p]),
         .is_empty   (port_empty[p]),
         .frees      (port_frees[p])
      );
   end

   assign O0_start  = port_start[0];
   assign O0_length = port_length[0];
   assign O0_data   = port_data[0];
   assign O0_end    = port_end[0];
   assign O0_req    = port_req[0];
   assign O1_start  = port_start[1];
   assign O1_length = port_length[1];
   assign O1_data   = port_data[1];
   assign O1_end    = port_end[1];
   assign O1_req    = port_req[1];
   assign O2_start  = port_start[2];
   assign O2_length = port_length[2];
   assign O2_data   = port_data[2];
   assign O2_end    = port_end[2];
   assign O2_req    = port_req[2];

endmodule

// File: tb/tb_gullfaxi.sv
// Self-checking bench for gullfaxi: directed scenarios plus random traffic against a queue-level model.
module tb_gullfaxi;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       I0_valid = 1'b0;
   logic [7:0] I0_data = 8'h00;
   logic       I0_end = 1'b0;
   logic       I0_ready;
   logic       O0_start, O1_start, O2_start;
   logic [5:0] O0_length, O1_length, O2_length;
   logic [7:0] O0_data, O1_data, O2_data;
   logic       O0_end, O1_end, O2_end;
   logic       O0_req, O1_req, O2_req;
   logic       O0_grant = 1'b0, O1_grant = 1'b0, O2_grant = 1'b0;

   int n_checks = 0;
   int n_errors = 0;
   bit rand_done = 0;

   always #5 clk = ~clk;

   gullfaxi dut (
      .clk(clk), .reset(reset),
      .I0_valid(I0_valid), .I0_data(I0_data), .I0_end(I0_end), .I0_ready(I0_ready),
      .O0_start(O0_start), .O0_length(O0_length), .O0_data(O0_data), .O0_end(O0_end),
      .O0_req(O0_req), .O0_grant(O0_grant),
      .O1_start(O1_start), .O1_length(O1_length), .O1_data(O1_data), .O1_end(O1_end),
      .O1_req(O1_req), .O1_grant(O1_grant),
      .O2_start(O2_start), .O2_length(O2_length), .O2_data(O2_data), .O2_end(O2_end),
      .O2_req(O2_req), .O2_grant(O2_grant)
   );

   wire [2:0] g_vec   = {O2_grant, O1_grant, O0_grant};
   wire [2:0] d_req   = {O2_req, O1_req, O0_req};
   wire [2:0] d_start = {O2_start, O1_start, O0_start};
   wire [2:0] d_end   = {O2_end, O1_end, O0_end};
   logic [5:0] d_len  [3];
   logic [7:0] d_data [3];
   assign d_len[0]  = O0_length;
   assign d_len[1]  = O1_length;
   assign d_len[2]  = O2_length;
   assign d_data[0] = O0_data;
   assign d_data[1] = O1_data;
   assign d_data[2] = O2_data;

   // Model: input mode 0 idle, 1 waiting, 2 receiving, 3 dropping; port phase 0 free, 1 held, 2 streaming.
   int         m_mode = 0;
   int         m_dest = 0;
   int         m_cnt = 0;
   logic [7:0] m_coll [64];
   int         m_ph  [3];
   int         m_pos [3];
   int         m_len [3];
   logic [7:0] m_buf [3][64];

   always @(posedge clk or negedge reset) begin : model_step
      bit acc;
      bit was_empty [3];
      bit was_freeing [3];
      if (!reset) begin
         m_mode = 0;
         m_cnt  = 0;
         m_dest = 0;
         for (int p = 0; p < 3; p++) begin
            m_ph[p] = 0; m_pos[p] = 0; m_len[p] = 0;
         end
      end else begin
         acc = I0_valid && (m_mode != 1);
         for (int p = 0; p < 3; p++) begin
            was_empty[p]   = (m_ph[p] == 0);
            was_freeing[p] = (m_ph[p] == 2) && (m_pos[p] == m_len[p] - 1);
         end
         for (int p = 0; p < 3; p++) begin
            if (m_ph[p] == 1 && g_vec[p]) begin
               m_ph[p] = 2; m_pos[p] = 0;
            end else if (m_ph[p] == 2) begin
               if (m_pos[p] == m_len[p] - 1) m_ph[p] = 0;
               else m_pos[p]++;
            end
         end
         case (m_mode)
            0: if (acc && !I0_end) begin
                  m_dest = int'(I0_data[1:0]);
                  m_cnt  = 0;
                  if (m_dest == 3) m_mode = 3;
                  else if (was_empty[m_dest]) m_mode = 2;
                  else m_mode = 1;
               end
            1: if (was_empty[m_dest] || was_freeing[m_dest]) m_mode = 2;
            2: if (acc) begin
                  if (m_cnt == 63) m_mode = I0_end ? 0 : 3;
                  else begin
                     m_coll[m_cnt] = I0_data;
                     m_cnt++;
                     if (I0_end) begin
                        for (int i = 0; i < m_cnt; i++) m_buf[m_dest][i] = m_coll[i];
                        m_len[m_dest] = m_cnt;
                        m_ph[m_dest]  = 1;
                        m_mode        = 0;
                     end
                  end
               end
            3: if (acc && I0_end) m_mode = 0;
            default: m_mode = 0;
         endcase
      end
   end

   task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Every cycle, compare all DUT outputs against what the model says they must be.
   always @(negedge clk) begin : compare
      bit         ex_send;
      bit         ex_start;
      logic [5:0] ex_len;
      logic [7:0] ex_data;
      checkOutput("I0_ready", 8'(I0_ready), 8'(reset && (m_mode != 1)));
      for (int p = 0; p < 3; p++) begin
         ex_send  = (m_ph[p] == 2);
         ex_start = ex_send && (m_pos[p] == 0);
         ex_len   = ex_start ? 6'(m_len[p]) : 6'd0;
         ex_data  = ex_send ? m_buf[p][m_pos[p]] : 8'h00;
         checkOutput($sformatf("O%0d_req", p),    8'(d_req[p]),   8'(m_ph[p] == 1));
         checkOutput($sformatf("O%0d_start", p),  8'(d_start[p]), 8'(ex_start));
         checkOutput($sformatf("O%0d_length", p), 8'(d_len[p]),   8'(ex_len));
         checkOutput($sformatf("O%0d_data", p),   d_data[p],      ex_data);
         checkOutput($sformatf("O%0d_end", p),    8'(d_end[p]),   8'(ex_send && (m_pos[p] == m_len[p] - 1)));
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic applyStimulus(input logic [7:0] d, input logic e);
      bit acc = 0;
      I0_valid = 1'b1;
      I0_data  = d;
      I0_end   = e;
      for (int i = 0; i < 400 && !acc; i++) begin
         @(negedge clk);
         acc = I0_ready;
         @(posedge clk);
         #1;
      end
      I0_valid = 1'b0;
      I0_end   = 1'b0;
      I0_data  = 8'h00;
      if (!acc) begin
         n_checks++;
         n_errors++;
         $display("[TB] FAIL accept_timeout: byte 0x%0h never accepted, ready required", d);
      end
   endtask

   task automatic send_packet(input logic [7:0] hdr, input int len, input logic [7:0] base, input bit rnd);
      applyStimulus(hdr, len == 0);
      for (int i = 0; i < len; i++) begin
         if (rnd && $urandom_range(0, 4) == 0) idle(1);
         applyStimulus(rnd ? 8'($urandom) : base + 8'(i), i == len - 1);
      end
   endtask

   task automatic wait_req(input int p);
      bit seen = 0;
      for (int i = 0; i < 300 && !seen; i++) begin
         @(negedge clk);
         seen = d_req[p];
         @(posedge clk);
         #1;
      end
      if (!seen) begin
         n_checks++;
         n_errors++;
         $display("[TB] FAIL req_timeout: O%0d_req stayed 0, expected 1", p);
      end
   endtask

   task automatic pulse_grant(input logic [2:0] m);
      {O2_grant, O1_grant, O0_grant} = m;
      @(posedge clk);
      #1;
      {O2_grant, O1_grant, O0_grant} = 3'b000;
   endtask

   initial begin
      int len;
      int r;
      idle(3);
      checkOutput("rst_ready", 8'(I0_ready), 8'h00);
      checkOutput("rst_req1", 8'(O1_req), 8'h00);
      reset = 1'b1;
      idle(1);
      checkOutput("ready_after_rst", 8'(I0_ready), 8'h01);

      $display("[TB] three-byte packet to port 1");
      applyStimulus(8'h01, 1'b0);
      applyStimulus(8'hA1, 1'b0);
      applyStimulus(8'hA2, 1'b0);
      applyStimulus(8'hA3, 1'b1);
      checkOutput("t1_req_rise", 8'(O1_req), 8'h01);
      idle(1);
      pulse_grant(3'b010);
      checkOutput("t1_start", 8'(O1_start), 8'h01);
      checkOutput("t1_length", 8'(O1_length), 8'h03);
      checkOutput("t1_byte0", O1_data, 8'hA1);
      idle(1);
      checkOutput("t1_byte1", O1_data, 8'hA2);
      idle(1);
      checkOutput("t1_byte2", O1_data, 8'hA3);
      checkOutput("t1_end", 8'(O1_end), 8'h01);
      checkOutput("t1_port0_idle", 8'(O0_req | O0_start), 8'h00);
      checkOutput("t1_port2_idle", 8'(O2_req | O2_start), 8'h00);
      idle(2);

      $display("[TB] back-to-back packets to port 0");
      send_packet(8'h04, 4, 8'h10, 1'b0);
      applyStimulus(8'h08, 1'b0);
      checkOutput("t2_ready_wait", 8'(I0_ready), 8'h00);
      fork
         begin
            for (int i = 0; i < 5; i++) applyStimulus(8'h20 + 8'(i), i == 4);
         end
         begin
            idle(3);
            pulse_grant(3'b001);
            idle(3);
            checkOutput("t2_end_byte", 8'(O0_end), 8'h01);
            checkOutput("t2_still_wait", 8'(I0_ready), 8'h00);
            idle(1);
            checkOutput("t2_ready_back", 8'(I0_ready), 8'h01);
         end
      join
      wait_req(0);
      pulse_grant(3'b001);
      checkOutput("t2_second_len", 8'(O0_length), 8'h05);
      idle(8);

      $display("[TB] dropped and oversize packets");
      send_packet(8'h03, 5, 8'h30, 1'b0);
      send_packet(8'h02, 64, 8'h40, 1'b0);
      idle(2);
      checkOutput("t3_no_req", 8'(d_req), 8'h00);

      $display("[TB] parallel transmission on ports 0 and 2");
      send_packet(8'h00, 3, 8'h50, 1'b0);
      send_packet(8'h02, 6, 8'h60, 1'b0);
      wait_req(2);
      pulse_grant(3'b101);
      checkOutput("t4_start0", 8'(O0_start), 8'h01);
      checkOutput("t4_len0", 8'(O0_length), 8'h03);
      checkOutput("t4_data0", O0_data, 8'h50);
      checkOutput("t4_start2", 8'(O2_start), 8'h01);
      checkOutput("t4_len2", 8'(O2_length), 8'h06);
      checkOutput("t4_data2", O2_data, 8'h60);
      idle(8);

      $display("[TB] single-byte payload");
      applyStimulus(8'h00, 1'b0);
      applyStimulus(8'h5A, 1'b1);
      wait_req(0);
      pulse_grant(3'b001);
      checkOutput("t5_start", 8'(O0_start), 8'h01);
      checkOutput("t5_end", 8'(O0_end), 8'h01);
      checkOutput("t5_len", 8'(O0_length), 8'h01);
      checkOutput("t5_data", O0_data, 8'h5A);
      idle(2);

      $display("[TB] reset during receive and during send");
      applyStimulus(8'h01, 1'b0);
      applyStimulus(8'h11, 1'b0);
      applyStimulus(8'h12, 1'b0);
      #2 reset = 1'b0;
      #1;
      checkOutput("t6_rx_ready", 8'(I0_ready), 8'h00);
      checkOutput("t6_rx_req", 8'(d_req), 8'h00);
      idle(2);
      reset = 1'b1;
      send_packet(8'h02, 5, 8'h70, 1'b0);
      wait_req(2);
      pulse_grant(3'b100);
      idle(1);
      #2 reset = 1'b0;
      #1;
      checkOutput("t6_tx_data", O2_data, 8'h00);
      checkOutput("t6_tx_end", 8'(O2_end), 8'h00);
      checkOutput("t6_tx_ready", 8'(I0_ready), 8'h00);
      idle(2);
      reset = 1'b1;
      send_packet(8'h01, 2, 8'h80, 1'b0);
      wait_req(1);
      pulse_grant(3'b010);
      checkOutput("t6_fresh_start", 8'(O1_start), 8'h01);
      checkOutput("t6_fresh_len", 8'(O1_length), 8'h02);
      checkOutput("t6_fresh_data", O1_data, 8'h80);
      idle(3);

      $display("[TB] random traffic");
      fork
         begin
            for (int k = 0; k < 60; k++) begin
               r = $urandom_range(0, 19);
               if (r == 0)      len = 0;
               else if (r == 1) len = $urandom_range(64, 66);
               else if (r == 2) len = 63;
               else             len = $urandom_range(1, 10);
               send_packet(8'($urandom), len, 8'h00, 1'b1);
            end
            rand_done = 1;
         end
         begin
            while (!rand_done) begin
               O0_grant = ($urandom_range(0, 2) == 0);
               O1_grant = ($urandom_range(0, 2) == 0);
               O2_grant = ($urandom_range(0, 2) == 0);
               idle(1);
            end
            {O2_grant, O1_grant, O0_grant} = 3'b000;
         end
      join
      {O2_grant, O1_grant, O0_grant} = 3'b111;
      idle(200);
      {O2_grant, O1_grant, O0_grant} = 3'b000;
      idle(2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not complete, expected finish before %0t", $time);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/gullfaxi.md
Name: gullfaxi

Overview:
- Single-input, three-output store-and-forward byte packet router.
- Accepts packets on a ready/valid byte stream and reads the destination from the header byte.
- Buffers each packet in a per-destination buffer, then requests the output channel.
- Once granted, emits start, length and the payload bytes, marking the last one with end.
- Sits between a packet source and three arbitrated downstream consumers.

Parameters:
- None. Widths and limits are fixed constants in gullfaxi_pkg: NUM_PORTS=3, DATA_W=8, LEN_W=6, MAX_LEN=63.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- I0_valid  in  1  input byte valid.
- I0_data  in  8  input byte.
- I0_end  in  1  marks last byte of the packet; qualified by I0_valid.
- I0_ready  out  1  router accepts a byte on a cycle where valid&&ready.
- On_start  out  1  (n=0,1,2) one-cycle pulse on the first payload byte.
- On_length  out  6  (n=0,1,2) payload byte count; valid only while On_start=1, else 0.
- On_data  out  8  (n=0,1,2) payload byte; 0 when not sending.
- On_end  out  1  (n=0,1,2) high on the last payload byte.
- On_req  out  1  (n=0,1,2) a complete packet is waiting.
- On_grant  in  1  (n=0,1,2) downstream grant; sampled only while On_req=1.

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs go to 0; I0_ready is forced 0 while reset is low.
  - Input FSM goes to IDLE; all buffers are emptied.
  - A partial packet or an in-flight transmission is discarded without emitting end.
- Packet format:
  - Byte 0 is the header: bits[1:0] = destination (0..2; 3 = drop); bits[7:2] are ignored.
  - Header is not forwarded. Remaining bytes are payload, length 1..63.
- Input FSM states: IDLE, WAIT, RECV, DROP. I0_ready=1 in IDLE, RECV and DROP; 0 in WAIT.
- Transitions:
  - IDLE: on an accepted header:
    - dest=3, or header carries I0_end (zero payload) -> DROP, or stay IDLE if I0_end was on the header.
    - Destination buffer empty -> RECV.
    - Destination buffer occupied -> WAIT.
  - WAIT -> RECV in the cycle after the destination buffer frees.
  - RECV: each accepted byte is written at address = count, count increments.
    - Accepted byte with I0_end: buffer marked FULL with length=count+1; FSM -> IDLE.
    - 64th payload byte accepted without I0_end: packet is oversize -> DROP; buffer stays empty.
  - DROP: consume bytes until an accepted I0_end, then -> IDLE. Nothing is emitted.
- Output port FSM, per port: EMPTY, FULL, SEND.
  - EMPTY -> FULL the cycle after the last byte is accepted. On_req=1 from that cycle.
  - FULL: first rising edge with On_grant=1 -> SEND.
    - In the next cycle On_req=0, On_start=1, On_length=L, On_data=byte0.
  - SEND: one byte per cycle, no stalls. On_end=1 with byte L-1; for L=1, start and end coincide.
    - Then -> EMPTY. The buffer is reusable the following cycle.
  - Grant while the port is not FULL is ignored.
- Concurrency:
  - The three ports are independent; simultaneous grants mean simultaneous transmissions.
  - Receiving into one port overlaps with sending on the others.
- Latency: last input byte accepted at cycle t -> On_req at t+1 -> grant at t+k -> On_start at t+k+1.
- I0_valid=0 gaps inside a packet are allowed; count holds.

Decomposition:
- gullfaxi_pkg holds:
  - constants NUM_PORTS, DATA_W, LEN_W, MAX_LEN, DEST_DROP=2'd3;
  - enums in_state_t {IDLE,WAIT,RECV,DROP} and out_state_t {EMPTY,FULL,SEND}.
- Sub-module gullfaxi_out_port: 64x8 buffer, write port, length register, output FSM and req/grant handshake. Instantiated 3 times.
- The top holds the input FSM and destination decode.

Test Plan:
- Header 0x01, payload {0xA1,0xA2,0xA3} with end on 0xA3; grant port 1 one cycle after req:
  - O1_req rises the cycle after 0xA3 is accepted.
  - O1_start=1 with O1_length=3 and O1_data=0xA1, then 0xA2, then 0xA3 with O1_end.
  - Ports 0 and 2 stay idle.
- Two packets to port 0 back-to-back, grant withheld:
  - I0_ready drops after the second header (WAIT).
  - Asserting O0_grant -> first packet sent; ready returns the cycle after its end byte.
  - Second packet is then received and requested.
- Header 0x03 plus 5 bytes, and separately a 64-byte payload to port 2:
  - Both are consumed with I0_ready=1; no req on any port.
- Packets to ports 0 and 2; O0_grant and O2_grant asserted in the same cycle:
  - Both transmit in parallel with correct lengths and data.
- Single-byte payload 0x5A to port 0:
  - One cycle with O0_start=O0_end=1, O0_length=1, O0_data=0x5A.
- reset pulled low mid-RECV and mid-SEND:
  - All outputs 0 immediately; no end is emitted.
  - After release, a fresh packet routes correctly.
